// File: rtl/ref_gen_pkg.sv
// -----------------------------------------------------------------------------
// ref_gen_pkg
// Shared definitions for the swept half-bridge reference generator:
//   - state_e        : FSM state encoding (IDLE, RUN, DRAIN)
//   - calc_cnt_mid   : base half-period count, so that the output sits at
//                      FREQ_MID_KHZ when the code is at mid-scale
//   - clamp_code     : limits an input code to the maximum legal code
// No ports; imported by ref_gen_sweep and sweep_code_step.
// -----------------------------------------------------------------------------
package ref_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Half-period at mid code is 500*CLK_MHZ/FREQ_MID_KHZ cycles; the code
    // adds on top of CNT_MID, so subtract half the code range.
    function automatic int unsigned calc_cnt_mid(
        input int unsigned clk_mhz,
        input int unsigned freq_mid_khz,
        input int unsigned gen_parameter
    );
        return (500 * clk_mhz) / freq_mid_khz - gen_parameter / 2;
    endfunction

    function automatic logic [31:0] clamp_code(
        input logic [31:0] code,
        input logic [31:0] max_code
    );
        return (code > max_code) ? max_code : code;
    endfunction

endpackage

// File: rtl/ref_gen_sweep_code_step.sv
// -----------------------------------------------------------------------------
// sweep_code_step
// Combinational next-code and direction logic for the triangular sweep.
// Ports:
//   code_cur    in   CW      code of the half-period now ending
//   code_lo     in   CW      sweep lower bound (already clamped to max code)
//   code_hi     in   CW      sweep upper bound (already clamped to max code)
//   step        in   STEP_W  increment per full output period
//   dir_up      in   1       current direction (1 = counting up)
//   code_hold   out  CW      current code forced into [lo, hi] (no step)
//   code_next   out  CW      stepped code for the next period
//   dir_up_next out  1       direction after this step
// -----------------------------------------------------------------------------
module sweep_code_step
    import ref_gen_pkg::*;
#(
    parameter int CW     = 8,
    parameter int STEP_W = 4
) (
    input  logic [CW-1:0]     code_cur,
    input  logic [CW-1:0]     code_lo,
    input  logic [CW-1:0]     code_hi,
    input  logic [STEP_W-1:0] step,
    input  logic              dir_up,
    output logic [CW-1:0]     code_hold,
    output logic [CW-1:0]     code_next,
    output logic              dir_up_next
);

    // One extra bit so code + step cannot wrap before saturation.
    localparam int SW = CW + 1;

    logic [SW-1:0] sum_w;
    logic [SW-1:0] lo_plus_w;
    logic [CW-1:0] step_cw;

    always_comb begin
        code_hold   = code_cur;
        code_next   = code_cur;
        dir_up_next = dir_up;
        step_cw     = CW'(step);

        // A mode switch mid-run can leave the code outside the window.
        if (code_cur < code_lo) begin
            code_hold = code_lo;
        end else if (code_cur > code_hi) begin
            code_hold = code_hi;
        end

        sum_w     = {1'b0, code_hold} + SW'(step);
        lo_plus_w = {1'b0, code_lo} + SW'(step);

        if (code_lo >= code_hi) begin
            // Degenerate window: park on the lower bound.
            code_hold   = code_lo;
            code_next   = code_lo;
            dir_up_next = 1'b1;
        end else if (dir_up) begin
            if (sum_w >= {1'b0, code_hi}) begin
                code_next   = code_hi;
                dir_up_next = 1'b0;
            end else begin
                code_next = sum_w[CW-1:0];
            end
        end else begin
            // code - step <= lo, rearranged to avoid an unsigned underflow.
            if ({1'b0, code_hold} <= lo_plus_w) begin
                code_next   = code_lo;
                dir_up_next = 1'b1;
            end else begin
                code_next = code_hold - step_cw;
            end
        end
    end

endmodule

// File: rtl/ref_gen_sweep.sv
// -----------------------------------------------------------------------------
// ref_gen_sweep
// Square-wave half-bridge reference with a run-time reloadable half-period.
// Half-period = CNT_MID + code cycles; code comes from code_in (fixed mode)
// or from a triangular sweep between code_lo and code_hi that advances once
// per full output period. A high half-period is never cut short except by
// reset; stopping drains the current high half first.
// Ports:
//   clk       in   1       system clock
//   rst_n     in   1       synchronous active-low reset
//   en        in   1       run request
//   mode      in   1       0 = fixed code, 1 = triangular sweep
//   code_in   in   CW      fixed-mode code
//   code_lo   in   CW      sweep lower bound
//   code_hi   in   CW      sweep upper bound
//   step      in   STEP_W  sweep increment per full period
//   out       out  1       reference square wave
//   edge_stb  out  1       one-cycle pulse in the cycle out changes
//   cur_code  out  CW      code governing the current half-period
//   busy      out  1       high in RUN and DRAIN
// -----------------------------------------------------------------------------
module ref_gen_sweep
    import ref_gen_pkg::*;
#(
    parameter int unsigned CLK_MHZ       = 100,
    parameter int unsigned FREQ_MID_KHZ  = 200,
    parameter int unsigned GEN_PARAMETER = 255,
    parameter int unsigned STEP_W        = 4,
    localparam int CW = $clog2(GEN_PARAMETER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [CW-1:0]     code_in,
    input  logic [CW-1:0]     code_lo,
    input  logic [CW-1:0]     code_hi,
    input  logic [STEP_W-1:0] step,
    output logic              out,
    output logic              edge_stb,
    output logic [CW-1:0]     cur_code,
    output logic              busy
);

    localparam int unsigned CNT_MID = calc_cnt_mid(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER);
    localparam int          CNT_W   = $clog2(CNT_MID + GEN_PARAMETER);

    // Counter load for a half-period of CNT_MID + code cycles: the load
    // cycle itself counts as the first cycle of the half.
    function automatic logic [CNT_W-1:0] half_load(input logic [CW-1:0] c);
        return CNT_W'(CNT_MID - 1) + CNT_W'(c);
    endfunction

    state_e           state_q, state_d;
    logic             out_q, out_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    code_q, code_d;
    logic             dir_up_q, dir_up_d;

    logic [CW-1:0]    code_in_c;
    logic [CW-1:0]    code_lo_c;
    logic [CW-1:0]    code_hi_c;
    logic [CW-1:0]    sweep_hold;
    logic [CW-1:0]    sweep_next;
    logic             sweep_dir_next;

    always_comb begin
        code_in_c = CW'(clamp_code(32'(code_in), 32'(GEN_PARAMETER)));
        code_lo_c = CW'(clamp_code(32'(code_lo), 32'(GEN_PARAMETER)));
        code_hi_c = CW'(clamp_code(32'(code_hi), 32'(GEN_PARAMETER)));
    end

    sweep_code_step #(
        .CW     (CW),
        .STEP_W (STEP_W)
    ) u_sweep_code_step (
        .code_cur    (code_q),
        .code_lo     (code_lo_c),
        .code_hi     (code_hi_c),
        .step        (step),
        .dir_up      (dir_up_q),
        .code_hold   (sweep_hold),
        .code_next   (sweep_next),
        .dir_up_next (sweep_dir_next)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        edge_d   = 1'b0;
        cnt_d    = cnt_q;
        code_d   = code_q;
        dir_up_d = dir_up_q;

        case (state_q)
            IDLE: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (en) begin
                    state_d  = RUN;
                    out_d    = 1'b1;
                    edge_d   = 1'b1;
                    dir_up_d = 1'b1;
                    code_d   = mode ? code_lo_c : code_in_c;
                    cnt_d    = half_load(code_d);
                end
            end

            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    // Dropping en during a high half lets it run to term.
                    if (!en && out_q) begin
                        state_d = DRAIN;
                    end
                end else if (out_q) begin
                    // 1 -> 0 toggle: the only point where the sweep advances.
                    out_d  = 1'b0;
                    edge_d = 1'b1;
                    if (!en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (mode) begin
                            code_d   = sweep_next;
                            dir_up_d = sweep_dir_next;
                        end else begin
                            code_d = code_in_c;
                        end
                        cnt_d = half_load(code_d);
                    end
                end else begin
                    // End of a low half: stop quietly or start the next high.
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        out_d  = 1'b1;
                        edge_d = 1'b1;
                        code_d = mode ? sweep_hold : code_in_c;
                        cnt_d  = half_load(code_d);
                    end
                end
            end

            DRAIN: begin
                // en is deliberately ignored here until back in IDLE.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_d   = 1'b0;
                    edge_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= 1'b0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            code_q   <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign out      = out_q;
    assign edge_stb = edge_q;
    assign cur_code = code_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/ref_gen_sweep.md
# ref_gen_sweep

Parametrised successor to the fixed-code reference generator: a square-wave half-bridge reference whose half-period is reloaded at run time on every toggle, with a fixed-code mode and a triangular frequency-sweep mode for resonance hunting. Feeds the DRSSTC gate-drive path in place of the fixed generator. Supports gated start/stop, never truncates a high pulse, and exports a toggle strobe and the active code for the phase-lock and telemetry logic.

## Interface
- CLK_MHZ, 100, system clock in MHz
- FREQ_MID_KHZ, 200, output frequency at code = GEN_PARAMETER/2
- GEN_PARAMETER, 255, maximum code; code width CW = $clog2(GEN_PARAMETER+1)
- STEP_W, 4, sweep step width
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  run request
- mode  in  1  0 = fixed code, 1 = triangular sweep
- code_in  in  CW  fixed-mode code
- code_lo  in  CW  sweep lower bound
- code_hi  in  CW  sweep upper bound
- step  in  STEP_W  sweep increment per full output period
- out  out  1  reference square wave
- edge_stb  out  1  one-cycle pulse in the cycle out changes
- cur_code  out  CW  code governing the current half-period
- busy  out  1  high in RUN and DRAIN

## Operation
- CNT_MID = 500*CLK_MHZ/FREQ_MID_KHZ − GEN_PARAMETER/2 (integer division, elaboration constant). Half-period = CNT_MID + code cycles.
- Input codes are clamped to GEN_PARAMETER before use.
- States: IDLE, RUN, DRAIN.
  - IDLE: out = 0, counter = 0. When en = 1, go to RUN, set out = 1, pulse edge_stb, load code and counter = CNT_MID + code − 1.
  - RUN: decrement the counter. At 0, toggle out, pulse edge_stb, and reload with the new code.
    - If en = 0 at the 0 cycle and out = 1, toggle out to 0 and go to IDLE.
    - If en = 0 while out = 1 before the counter reaches 0, go to DRAIN.
    - If en = 0 while out = 0, finish the low half, then go to IDLE without reasserting out.
  - DRAIN: finish the current high half-period. At 0, out = 0, pulse edge_stb, go to IDLE. A reasserted en is ignored until IDLE.
- Code update happens only at reload; inputs are don't-care between reloads.
  - Fixed mode: code = clamp(code_in).
  - Sweep mode: code advances once per full period, at the 1→0 toggle only.
    - The up/down direction register resets to up.
    - code += step while up. On reaching or exceeding code_hi, saturate to code_hi and set down.
    - On reaching or falling below code_lo, saturate to code_lo and set up.
    - If code_lo ≥ code_hi, code holds at code_lo.
    - On the IDLE→RUN transition in sweep mode, code starts at code_lo with direction up.
- A mode change is honoured at the next reload. Switching into sweep mid-run continues from the current code, clamped into [lo, hi].
- Counter width = $clog2(CNT_MID + GEN_PARAMETER). Arithmetic is unsigned, and sweep sums are computed at CW+1 bits before saturation.

## Timing
- Reset (rst_n = 0 at a posedge):
  - out = 0, edge_stb = 0, busy = 0, cur_code = 0, state IDLE, direction up.
  - Reset overrides everything in the same edge, including mid-pulse. A truncated pulse is permitted only on reset.
- Start latency: en sampled high in IDLE gives out = 1 and busy = 1 at the next posedge.
- edge_stb is registered and coincident with the out change.
- Every half-period is exactly CNT_MID + code cycles. Duty is 50 % for a constant code.
- cur_code changes in the same cycle as edge_stb.
- Stop: out is low at most one half-period after en falls, and never by cutting a high half short.

## Structure
- Shared package ref_gen_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - the CNT_MID computation function
  - the clamp function
- One natural sub-module: sweep_code_step, which is combinational next-code plus direction logic for the sweep mode.
- The top holds the FSM, counter and output registers.

## Test plan
All cases use default parameters, so CNT_MID = 123.
- Fixed, code_in = 127, en held high: out period 500 cycles (200 kHz), high 250, edge_stb every 250 cycles, first out = 1 one cycle after en.
- Fixed, code_in changed 127→0 mid high-half: the current half stays 250 cycles and the next half is 123 cycles.
- Sweep, lo = 100, hi = 110, step = 4: successive per-period codes are 100, 104, 108, 110, 106, 102, 100, 104…
- en dropped 10 cycles into a high half (code 127): out stays high 240 more cycles, then 0 with busy = 0. A re-raised en during DRAIN is ignored until IDLE.
- rst_n low mid-pulse: next posedge gives out = 0, busy = 0, cur_code = 0. Restarting sweep then begins at code_lo.
- code_in = 300 (CW = 8 so 255 max via tb width ext. n/a) and code_lo = 200, hi = 50: fixed half = 123 + 255 = 378 cycles on clamp check; sweep holds at 200.
